// File: rtl/alu4_arbiter.sv
// rtl/alu4_arbiter.sv - round-robin arbiter sharing one alu4 datapath between two requesters
// Optional feature macro: ALU4_ARB_DZ_BYPASS_EN (divide-by-zero short-circuit in IDLE)

module alu4_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_cin,
  input  logic       req0_dir,
  input  logic       req0_arith,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_cin,
  input  logic       req1_dir,
  input  logic       req1_arith,
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic       alu_dir,
  output logic       alu_arith,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_y_hi,
  input  logic       alu_cout,
  input  logic       alu_div_by_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  output logic [3:0] rsp_y_hi,
  output logic       rsp_cout,
  output logic       rsp_dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value reached on the edge that should capture the ALU result.
  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       cur_id;
  logic [3:0] cnt;
  logic       any_valid;
  logic       grant;
  logic       accept;
  logic       wait_done;
  logic       dz_bypass;
  logic [3:0] sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic       sel_cin;
  logic       sel_dir;
  logic       sel_arith;

  // Round-robin choice: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept     = (state == IDLE) && any_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign wait_done  = (cnt == WAIT_LAST);
  assign rsp_valid  = (state == RESP);

  // Operand fields of the granted requester.
  always_comb begin
    sel_op    = grant ? req1_op    : req0_op;
    sel_a     = grant ? req1_a     : req0_a;
    sel_b     = grant ? req1_b     : req0_b;
    sel_cin   = grant ? req1_cin   : req0_cin;
    sel_dir   = grant ? req1_dir   : req0_dir;
    sel_arith = grant ? req1_arith : req0_arith;
  end

`ifdef ALU4_ARB_DZ_BYPASS_EN
  assign dz_bypass = (sel_op == 4'd11) && (sel_b == 4'd0);
`else
  assign dz_bypass = 1'b0;
`endif

  // Next-state logic for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = dz_bypass ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (wait_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch on acceptance, wait counter, and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= 4'd0;
      alu_op     <= 4'd0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_cin    <= 1'b0;
      alu_dir    <= 1'b0;
      alu_arith  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= 4'd0;
      rsp_y_hi   <= 4'd0;
      rsp_cout   <= 1'b0;
      rsp_dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            cur_id     <= grant;
            cnt        <= 4'd0;
            if (dz_bypass) begin
              rsp_id   <= grant;
              rsp_y    <= 4'd0;
              rsp_y_hi <= 4'd0;
              rsp_cout <= 1'b0;
              rsp_dz   <= 1'b1;
            end else begin
              alu_op    <= sel_op;
              alu_a     <= sel_a;
              alu_b     <= sel_b;
              alu_cin   <= sel_cin;
              alu_dir   <= sel_dir;
              alu_arith <= sel_arith;
            end
          end
        end
        EXEC: begin
          if (wait_done) begin
            rsp_id   <= cur_id;
            rsp_y    <= alu_y;
            rsp_y_hi <= alu_y_hi;
            rsp_cout <= alu_cout;
            rsp_dz   <= alu_div_by_zero;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
